// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers returned instructions with their
// PC and predicted-taken bit, and delivers them in order. A redirect flushes and drops in-flight replies.
module inst_fetch_queue #(
    parameter int                 DEPTH    = 4,
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              resp_valid_i,
    input  logic [DATA_W-1:0] resp_inst_i,
    input  logic              resp_taken_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_inst_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic              out_taken_o,
    input  logic              out_ready_i
);

    localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_fill;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_outst;
    logic [CNT_W-1:0]  r_drop;
    logic [DEPTH-1:0]  r_filled;
    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [DATA_W-1:0] r_inst  [DEPTH];
    logic              r_taken [DEPTH];

    logic              w_req_valid;
    logic              w_issue;
    logic              w_out_valid;
    logic              w_consume;
    logic              w_resp_drop;
    logic              w_resp_fill;
    logic [CNT_W-1:0]  w_redir_drop;
    logic [ADDR_W-1:0] w_redir_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [PTR_W-1:0]  w_head_nxt;
    logic [PTR_W-1:0]  w_fill_nxt;
    logic [PTR_W-1:0]  w_tail_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_outst_nxt;
    logic [CNT_W-1:0]  w_drop_nxt;

    // Handshake qualification for issue, response and consume.
    always_comb begin
        w_req_valid  = !rst && !redirect_i && (r_count < DEPTH_C) && (r_drop == '0);
        w_issue      = w_req_valid && req_ready_i;
        w_out_valid  = r_filled[r_head] && (r_count != '0);
        w_consume    = w_out_valid && out_ready_i;
        w_resp_drop  = resp_valid_i && (r_drop != '0);
        // A reply with nothing outstanding is a protocol error and is ignored.
        w_resp_fill  = resp_valid_i && (r_drop == '0) && (r_outst != '0);
        w_redir_pc   = redirect_pc_i & PC_MASK;
        if (r_drop != '0) begin
            w_redir_drop = r_outst + r_drop - CNT_W'(resp_valid_i);
        end else begin
            w_redir_drop = r_outst - CNT_W'(w_resp_fill);
        end
    end

    // Next-state for pointers, counters and fetch PC; redirect overrides every other event.
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_head_nxt     = r_head;
        w_fill_nxt     = r_fill;
        w_tail_nxt     = r_tail;
        w_count_nxt    = r_count;
        w_outst_nxt    = r_outst;
        w_drop_nxt     = r_drop;
        if (redirect_i) begin
            w_fetch_pc_nxt = w_redir_pc;
            w_head_nxt     = '0;
            w_fill_nxt     = '0;
            w_tail_nxt     = '0;
            w_count_nxt    = '0;
            w_outst_nxt    = '0;
            w_drop_nxt     = w_redir_drop;
        end else begin
            if (w_issue) begin
                w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
                w_tail_nxt     = ptr_inc(r_tail);
            end else begin
                w_fetch_pc_nxt = r_fetch_pc;
            end
            if (w_resp_fill) begin
                w_fill_nxt = ptr_inc(r_fill);
            end else begin
                w_fill_nxt = r_fill;
            end
            if (w_consume) begin
                w_head_nxt = ptr_inc(r_head);
            end else begin
                w_head_nxt = r_head;
            end
            if (w_resp_drop) begin
                w_drop_nxt = r_drop - CNT_W'(1);
            end else begin
                w_drop_nxt = r_drop;
            end
            w_count_nxt = r_count + CNT_W'(w_issue) - CNT_W'(w_consume);
            w_outst_nxt = r_outst + CNT_W'(w_issue) - CNT_W'(w_resp_fill);
        end
    end

    // Scalar control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_head     <= w_head_nxt;
            r_fill     <= w_fill_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_outst    <= w_outst_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    // Entry storage; tail, fill and head never alias when their events coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_inst[i]  <= '0;
                r_taken[i] <= 1'b0;
            end
        end else if (redirect_i) begin
            r_filled <= '0;
        end else begin
            if (w_issue) begin
                r_pc[r_tail]     <= r_fetch_pc;
                r_filled[r_tail] <= 1'b0;
            end
            if (w_resp_fill) begin
                r_inst[r_fill]   <= resp_inst_i;
                r_taken[r_fill]  <= resp_taken_i;
                r_filled[r_fill] <= 1'b1;
            end
            if (w_consume) begin
                r_filled[r_head] <= 1'b0;
            end
        end
    end

    assign req_valid_o = w_req_valid;
    assign req_addr_o  = rst ? '0 : r_fetch_pc;
    assign out_valid_o = w_out_valid;
    assign out_inst_o  = r_inst[r_head];
    assign out_pc_o    = r_pc[r_head];
    assign out_taken_o = r_taken[r_head];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench for inst_fetch_queue: a queue-level reference model feeds an expected-output
// scoreboard that an independent monitor drains whenever the DUT hands over an instruction.
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        resp_valid_i;
    logic [31:0] resp_inst_i;
    logic        resp_taken_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic        out_taken_o;
    logic        out_ready_i;

    item_t       exp_q[$];
    logic [31:0] pending[$];
    int          m_drop;
    logic [31:0] m_fetch_pc;
    bit          m_req_valid;
    int          b_outst;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH   (DEPTH),
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready_i),
        .resp_valid_i (resp_valid_i),
        .resp_inst_i  (resp_inst_i),
        .resp_taken_i (resp_taken_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .out_valid_o  (out_valid_o),
        .out_inst_o   (out_inst_o),
        .out_pc_o     (out_pc_o),
        .out_taken_o  (out_taken_o),
        .out_ready_i  (out_ready_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, 64'(req_valid_o), 64'd0);
        check({tag, "_req_addr"},  64'(req_addr_o),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_out_inst"},  64'(out_inst_o),  64'd0);
        check({tag, "_out_pc"},    64'(out_pc_o),    64'd0);
        check({tag, "_out_taken"}, 64'(out_taken_o), 64'd0);
    endtask

    // Reference model: state advances at each rising edge from this cycle's inputs.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pending.delete();
                exp_q.delete();
                m_drop      = 0;
                m_fetch_pc  = RESET_PC;
                m_req_valid = 1'b0;
                b_outst     = 0;
            end else if (redirect_i) begin
                if (resp_valid_i) begin
                    if (m_drop > 0) m_drop--;
                    else if (pending.size() > 0) void'(pending.pop_front());
                end
                m_drop     += pending.size();
                pending.delete();
                exp_q.delete();
                m_fetch_pc  = redirect_pc_i & 32'hFFFF_FFFC;
            end else begin
                if (resp_valid_i) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else if (pending.size() > 0) begin
                        item_t it;
                        it.pc    = pending.pop_front();
                        it.inst  = resp_inst_i;
                        it.taken = resp_taken_i;
                        exp_q.push_back(it);
                    end
                end
                if (m_req_valid && req_ready_i) begin
                    pending.push_back(m_fetch_pc);
                    m_fetch_pc += 32'd4;
                    b_outst++;
                end
            end
        end
    end

    // Monitor: mid-cycle comparison of DUT outputs with the model; pops the scoreboard on consume.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                bit ev;
                ev = !redirect_i && ((pending.size() + exp_q.size()) < DEPTH) && (m_drop == 0);
                m_req_valid = ev;
                check("req_valid", 64'(req_valid_o), 64'(ev));
                check("req_addr",  64'(req_addr_o),  64'(m_fetch_pc));
                check("out_valid", 64'(out_valid_o), 64'(exp_q.size() > 0));
                if (out_valid_o && exp_q.size() > 0) begin
                    check("out_pc",    64'(out_pc_o),    64'(exp_q[0].pc));
                    check("out_inst",  64'(out_inst_o),  64'(exp_q[0].inst));
                    check("out_taken", 64'(out_taken_o), 64'(exp_q[0].taken));
                    if (out_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus, including an in-order binder answering outstanding requests.
    task automatic drive(input bit rr, input bit orr, input int resp_pct, input int redir_pct);
        @(posedge clk);
        #1;
        req_ready_i = rr;
        out_ready_i = orr;
        if (b_outst > 0 && int'($urandom_range(99)) < resp_pct) begin
            resp_valid_i = 1'b1;
            resp_inst_i  = $urandom;
            resp_taken_i = 1'($urandom_range(1));
            b_outst--;
        end else begin
            resp_valid_i = 1'b0;
            resp_inst_i  = 32'd0;
            resp_taken_i = 1'b0;
        end
        if (int'($urandom_range(99)) < redir_pct) begin
            redirect_i = 1'b1;
            case ($urandom_range(2))
                0:       redirect_pc_i = 32'h0000_0103;
                1:       redirect_pc_i = 32'hFFFF_FFF8;
                default: redirect_pc_i = $urandom;
            endcase
        end else begin
            redirect_i    = 1'b0;
            redirect_pc_i = 32'd0;
        end
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(1)), ($urandom_range(99) < 60), 70, 4);
        end
    endtask

    initial begin
        rst           = 1'b1;
        req_ready_i   = 1'b0;
        resp_valid_i  = 1'b0;
        resp_inst_i   = 32'd0;
        resp_taken_i  = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        out_ready_i   = 1'b0;
        #1;
        check_all_zero("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with an always-ready binder and consumer.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 100, 0);
        // Fill to DEPTH with consumer stalled, release one slot, then drain.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 100, 0);
        drive(1'b1, 1'b1, 100, 0);
        for (int i = 0; i < 6; i++)  drive(1'b1, 1'b0, 100, 0);
        for (int i = 0; i < 8; i++)  drive(1'b1, 1'b1, 100, 0);

        random_phase(1500);

        // Asynchronous reset in the middle of a cycle with traffic in flight.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 50, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        b_outst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        req_ready_i   = 1'b1;
        out_ready_i   = 1'b1;
        redirect_i    = 1'b0;
        resp_valid_i  = 1'b1;
        resp_inst_i   = 32'hDEAD_BEEF;
        resp_taken_i  = 1'b1;

        random_phase(400);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
